// File: rtl/mem_access_ctrl_if.sv
// Bundles the request side and the RAM MOV/MOC bus of the memory access controller.
// master = the controller, slave = control unit plus RAM seen from outside.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req;
    logic [5:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wd_hi;
    logic [DATA_W-1:0] req_wd_lo;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rd_hi;
    logic [DATA_W-1:0] rd_lo;
    logic              MOV;
    logic              ReadWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [5:0]        OpCode;
    logic              MOC;
    logic              DMOC;
    logic [DATA_W-1:0] DataOut;

    modport master (
        input  req, req_op, req_addr, req_wd_hi, req_wd_lo, MOC, DMOC, DataOut,
        output busy, done, err, rd_hi, rd_lo, MOV, ReadWrite, Address, DataIn, OpCode
    );

    modport slave (
        output req, req_op, req_addr, req_wd_hi, req_wd_lo, MOC, DMOC, DataOut,
        input  busy, done, err, rd_hi, rd_lo, MOV, ReadWrite, Address, DataIn, OpCode
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the ram512x8 MOV/MOC handshake; a doubleword runs as two
// 32-bit phases at the same address, each phase checked against the RAM's DMOC flag.
module mem_access_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, DONE} state_t;

    state_t            state_q, state_d;
    logic              mov_q, mov_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [5:0]        opcode_q, opcode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_hi_q, rd_hi_d;
    logic [DATA_W-1:0] rd_lo_q, rd_lo_d;
    logic [DATA_W-1:0] wd_lo_q, wd_lo_d;
    logic              phase_q, phase_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_dw;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'b100011, 6'b100101, 6'b100001, 6'b100100, 6'b100000, 6'b110101,
            6'b101011, 6'b101001, 6'b101000, 6'b111111: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    endfunction

    assign is_dw = (opcode_q == 6'b110101) || (opcode_q == 6'b111111);

    always_comb begin
        state_d   = state_q;
        mov_d     = mov_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_in_d = data_in_q;
        opcode_d  = opcode_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rd_hi_d   = rd_hi_q;
        rd_lo_d   = rd_lo_q;
        wd_lo_d   = wd_lo_q;
        phase_d   = phase_q;
        abort_d   = abort_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    phase_d = 1'b0;
                    if (op_legal(bus.req_op)) begin
                        state_d   = ACCESS;
                        mov_d     = 1'b1;
                        rw_d      = ~bus.req_op[3];
                        addr_d    = bus.req_addr;
                        opcode_d  = bus.req_op;
                        data_in_d = bus.req_wd_hi;
                        wd_lo_d   = bus.req_wd_lo;
                        cnt_d     = '0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // A MOC seen on the first cycle is left over from the previous access.
                if (cnt_q != '0 && bus.MOC) begin
                    if (rw_q) begin
                        if (is_dw && !phase_q) begin
                            rd_hi_d = bus.DataOut;
                        end else begin
                            rd_lo_d = bus.DataOut;
                            if (!is_dw) rd_hi_d = '0;
                        end
                    end
                    // RAM raises DMOC after its first doubleword phase and clears it after the second.
                    if (is_dw && (bus.DMOC == phase_q)) err_d = 1'b1;
                    mov_d   = 1'b0;
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    mov_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (is_dw && !phase_q && !abort_q) begin
                    phase_d   = 1'b1;
                    data_in_d = wd_lo_q;
                    mov_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                phase_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mov_q     <= 1'b0;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            data_in_q <= '0;
            opcode_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_hi_q   <= '0;
            rd_lo_q   <= '0;
            wd_lo_q   <= '0;
            phase_q   <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mov_q     <= mov_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_in_q <= data_in_d;
            opcode_q  <= opcode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_hi_q   <= rd_hi_d;
            rd_lo_q   <= rd_lo_d;
            wd_lo_q   <= wd_lo_d;
            phase_q   <= phase_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.MOV       = mov_q;
    assign bus.ReadWrite = rw_q;
    assign bus.Address   = addr_q;
    assign bus.DataIn    = data_in_q;
    assign bus.OpCode    = opcode_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_hi     = rd_hi_q;
    assign bus.rd_lo     = rd_lo_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural big-endian RAM with MOC/DMOC, a scoreboard
// monitor popping expected {err, rd_hi, rd_lo} on every done, and directed requests.
module tb_mem_access_ctrl;
    localparam int AW = 9;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- RAM model (not touched by the DUT reset) ----------------
    logic [7:0] mem [0:511];
    logic       ram_init = 1'b1;
    logic       moc_en = 1'b1;
    logic       mov_prev;
    int         ra;

    always @(posedge clk) begin
        if (ram_init) begin
            bus.MOC     <= 1'b0;
            bus.DMOC    <= 1'b0;
            bus.DataOut <= '0;
            mov_prev    <= 1'b0;
        end else begin
            mov_prev <= bus.MOV;
            if (!bus.MOV) begin
                bus.MOC <= 1'b0;
            end else if (!mov_prev && moc_en) begin
                ra = int'(bus.Address);
                if (bus.OpCode == 6'b110101 || bus.OpCode == 6'b111111) begin
                    if (bus.DMOC) ra = ra + 4;
                    bus.DMOC <= ~bus.DMOC;
                end
                case (bus.OpCode)
                    6'b100011, 6'b110101:
                        bus.DataOut <= {mem[ra], mem[ra+1], mem[ra+2], mem[ra+3]};
                    6'b100100: bus.DataOut <= {24'h0, mem[ra]};
                    6'b101011, 6'b111111: begin
                        mem[ra]   = bus.DataIn[31:24];
                        mem[ra+1] = bus.DataIn[23:16];
                        mem[ra+2] = bus.DataIn[15:8];
                        mem[ra+3] = bus.DataIn[7:0];
                    end
                    6'b101000: mem[ra] = bus.DataIn[7:0];
                    default: bus.DataOut <= '0;
                endcase
                bus.MOC <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_err", 64'(bus.err), 64'(mon_e.err));
                check("sb_rd_hi", 64'(bus.rd_hi), 64'(mon_e.hi));
                check("sb_rd_lo", 64'(bus.rd_lo), 64'(mon_e.lo));
                $display("done: err=%0b rd_hi=%08h rd_lo=%08h", bus.err, bus.rd_hi, bus.rd_lo);
            end
        end
    end

    // ---------------- MOV pulse statistics ----------------
    logic mov_s = 1'b0;
    int rises = 0, high_run = 0, low_run = 0, last_high = 0, last_gap = 0;
    always @(negedge clk) begin
        if (bus.MOV && !mov_s) begin
            rises++;
            last_gap = low_run;
            high_run = 1;
        end else if (bus.MOV) begin
            high_run++;
        end else if (mov_s) begin
            last_high = high_run;
            low_run = 1;
        end else begin
            low_run++;
        end
        mov_s = bus.MOV;
    end

    task automatic check_rst(input string p);
        check({p, "_MOV"}, 64'(bus.MOV), 64'd0);
        check({p, "_ReadWrite"}, 64'(bus.ReadWrite), 64'd1);
        check({p, "_Address"}, 64'(bus.Address), 64'd0);
        check({p, "_DataIn"}, 64'(bus.DataIn), 64'd0);
        check({p, "_OpCode"}, 64'(bus.OpCode), 64'd0);
        check({p, "_busy"}, 64'(bus.busy), 64'd0);
        check({p, "_done"}, 64'(bus.done), 64'd0);
        check({p, "_err"}, 64'(bus.err), 64'd0);
        check({p, "_rd_hi"}, 64'(bus.rd_hi), 64'd0);
        check({p, "_rd_lo"}, 64'(bus.rd_lo), 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    // Issue one request; lat = edges after the sampling edge until done is registered.
    task automatic issue(input logic [5:0] op, input logic [8:0] a, input logic [31:0] hi,
                         input logic [31:0] lo, input logic e_err, input logic [31:0] e_hi,
                         input logic [31:0] e_lo, output int lat);
        exp_t e;
        wait_idle();
        e.err = e_err; e.hi = e_hi; e.lo = e_lo;
        sb_q.push_back(e);
        bus.req = 1'b1; bus.req_op = op; bus.req_addr = a;
        bus.req_wd_hi = hi; bus.req_wd_lo = lo;
        $display("req: op=%06b addr=%03h wd_hi=%08h wd_lo=%08h", op, a, hi, lo);
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) check("issue_done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int lat, r0, n;
        logic [7:0] exp_b [8];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
        bus.req = 1'b0; bus.req_op = '0; bus.req_addr = '0;
        bus.req_wd_hi = '0; bus.req_wd_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst("reset");
        reset = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);

        // 1: load word
        r0 = rises;
        issue(6'b100011, 9'h010, 32'h0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, lat);
        check("t1_latency", 64'(lat), 64'd3);
        check("t1_mov_pulses", 64'(rises - r0), 64'd1);
        check("t1_mov_len", 64'(last_high), 64'd2);

        // 2: store doubleword
        r0 = rises;
        issue(6'b111111, 9'h020, 32'h11223344, 32'h55667788, 1'b0, 32'h0, 32'hDEADBEEF, lat);
        check("t2_mov_pulses", 64'(rises - r0), 64'd2);
        check("t2_mov_gap", 64'(last_gap), 64'd1);
        for (int i = 0; i < 8; i++) check("t2_ram_byte", 64'(mem[32+i]), 64'(exp_b[i]));

        // 3: load doubleword back
        issue(6'b110101, 9'h020, 32'h0, 32'h0, 1'b0, 32'h11223344, 32'h55667788, lat);

        // store byte leaves rd unchanged; load byte unsigned clears rd_hi
        issue(6'b101000, 9'h030, 32'h000000AB, 32'h0, 1'b0, 32'h11223344, 32'h55667788, lat);
        check("sb_ram_byte", 64'(mem[48]), 64'hAB);
        issue(6'b100100, 9'h030, 32'h0, 32'h0, 1'b0, 32'h0, 32'h000000AB, lat);

        // 4: illegal opcode
        r0 = rises;
        issue(6'b000000, 9'h010, 32'h0, 32'h0, 1'b1, 32'h0, 32'h000000AB, lat);
        check("t4_latency", 64'(lat), 64'd0);
        check("t4_no_mov", 64'(rises - r0), 64'd0);

        // 5: no MOC -> timeout, single and doubleword
        moc_en = 1'b0;
        r0 = rises;
        issue(6'b100011, 9'h010, 32'h0, 32'h0, 1'b1, 32'h0, 32'h000000AB, lat);
        check("t5_mov_len", 64'(last_high), 64'd16);
        check("t5_mov_pulses", 64'(rises - r0), 64'd1);
        r0 = rises;
        issue(6'b110101, 9'h020, 32'h0, 32'h0, 1'b1, 32'h0, 32'h000000AB, lat);
        check("t5_dw_mov_pulses", 64'(rises - r0), 64'd1);
        moc_en = 1'b1;

        // req held high: two back-to-back word loads
        wait_idle();
        r0 = rises;
        mon_e.err = 1'b0; mon_e.hi = 32'h0; mon_e.lo = 32'hDEADBEEF;
        sb_q.push_back(mon_e);
        sb_q.push_back(mon_e);
        bus.req = 1'b1; bus.req_op = 6'b100011; bus.req_addr = 9'h010;
        $display("req: op=100011 addr=010 held high for two operations");
        n = 0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        bus.req = 1'b0;
        check("hold_done_count", 64'(n), 64'd2);
        check("hold_mov_pulses", 64'(rises - r0), 64'd2);
        check("hold_gap_ge2", 64'(last_gap >= 2), 64'd1);

        // 6: reset during phase 1 of a doubleword load, then a fresh doubleword load
        wait_idle();
        r0 = rises;
        mon_e.err = 1'b0; mon_e.hi = 32'h0; mon_e.lo = 32'h0;
        sb_q.push_back(mon_e);
        bus.req = 1'b1; bus.req_op = 6'b110101; bus.req_addr = 9'h020;
        $display("req: op=110101 addr=020 (reset during phase 1)");
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        n = 0;
        while (!(rises == r0 + 1 && !bus.MOV) && n < 100) begin @(negedge clk); #1; n++; end
        check("t6_phase0_seen", 64'(n < 100), 64'd1);
        moc_en = 1'b0;
        n = 0;
        while (rises != r0 + 2 && n < 100) begin @(negedge clk); #1; n++; end
        check("t6_phase1_seen", 64'(n < 100), 64'd1);
        reset = 1'b1;
        sb_q.delete(sb_q.size() - 1);
        @(posedge clk);
        @(negedge clk);
        check_rst("midrst");
        reset = 1'b0;
        moc_en = 1'b1;
        @(negedge clk);
        // RAM still has DMOC=1, so it serves +4 first and both phase checks mismatch
        issue(6'b110101, 9'h020, 32'h0, 32'h0, 1'b1, 32'h55667788, 32'h11223344, lat);

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
